// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - state encoding and default timings for btn_press_classifier (BTN_DOUBLE_CLICK_EN adds gap states)
package btn_pkg;

  localparam int LONG_CNT_DEF = 50_000_000;
  localparam int GAP_CNT_DEF  = 15_000_000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESSED   = 3'd1,
`ifdef BTN_DOUBLE_CLICK_EN
    WAIT_GAP  = 3'd3,
    SECOND    = 3'd4,
`endif
    LONG_HELD = 3'd2
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - one-cycle delayed button level with rise/fall strobes
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  output logic btn_d,
  output logic rise,
  output logic fall
);

  logic btn_d_q;
  logic btn_d_d;

  always_comb begin
    btn_d_d = btn_level;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_d_q <= 1'b0;
    end else begin
      btn_d_q <= btn_d_d;
    end
  end

  assign btn_d = btn_d_q;
  assign rise  = btn_level & ~btn_d_q;
  assign fall  = ~btn_level & btn_d_q;

endmodule

// File: rtl/btn_press_classifier.sv
// rtl/btn_press_classifier.sv - short/long/double-click classifier for a debounced button
// BTN_DOUBLE_CLICK_EN enables the release-gap window and double_click detection.
module btn_press_classifier
  import btn_pkg::*;
#(
  parameter int LONG_CNT = LONG_CNT_DEF,
  parameter int GAP_CNT  = GAP_CNT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic held
);

  localparam int CNT_W = $clog2(max_int(LONG_CNT, GAP_CNT));
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
`ifdef BTN_DOUBLE_CLICK_EN
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CNT - 1);
`endif

  logic btn_d;
  logic rise;
  logic fall;
  logic steady;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_press_q, short_press_d;
  logic             long_press_q, long_press_d;
  logic             held_q, held_d;
`ifdef BTN_DOUBLE_CLICK_EN
  logic             double_click_q, double_click_d;
`endif

  edge_detect u_edge (
    .clk       (clk),
    .rst       (rst),
    .btn_level (btn_level),
    .btn_d     (btn_d),
    .rise      (rise),
    .fall      (fall)
  );

  // Button down in both this and the previous cycle: the press is still going.
  assign steady = btn_level & btn_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    short_press_d = 1'b0;
    long_press_d  = 1'b0;
`ifdef BTN_DOUBLE_CLICK_EN
    double_click_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        cnt_d = cnt_q + 1'b1;
        if (fall) begin
`ifdef BTN_DOUBLE_CLICK_EN
          state_d = WAIT_GAP;
`else
          state_d       = IDLE;
          short_press_d = 1'b1;
`endif
        end else if (steady && (cnt_q == LONG_LAST)) begin
          state_d      = LONG_HELD;
          long_press_d = 1'b1;
        end
      end
      LONG_HELD: begin
        if (fall) begin
          state_d = IDLE;
        end
      end
`ifdef BTN_DOUBLE_CLICK_EN
      WAIT_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (rise) begin
          state_d = SECOND;
        end else if (cnt_q == GAP_LAST) begin
          state_d       = IDLE;
          short_press_d = 1'b1;
        end
      end
      SECOND: begin
        cnt_d = cnt_q + 1'b1;
        if (fall) begin
          state_d        = IDLE;
          double_click_d = 1'b1;
        end else if (steady && (cnt_q == LONG_LAST)) begin
          state_d      = LONG_HELD;
          long_press_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
    // Every counting state exits at its terminal value, so clearing on
    // each transition keeps cnt from ever wrapping.
    if (state_d != state_q) begin
      cnt_d = '0;
    end
    held_d = (state_d == LONG_HELD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      short_press_q <= 1'b0;
      long_press_q  <= 1'b0;
      held_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      short_press_q <= short_press_d;
      long_press_q  <= long_press_d;
      held_q        <= held_d;
    end
  end

`ifdef BTN_DOUBLE_CLICK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      double_click_q <= 1'b0;
    end else begin
      double_click_q <= double_click_d;
    end
  end
  assign double_click = double_click_q;
`else
  assign double_click = 1'b0;
`endif

  assign short_press = short_press_q;
  assign long_press  = long_press_q;
  assign held        = held_q;

endmodule

// File: tb/tb_btn_press_classifier.sv
// tb/tb_btn_press_classifier.sv - scoreboard bench for btn_press_classifier (follows BTN_DOUBLE_CLICK_EN)
module tb_btn_press_classifier;

  localparam int LONG_CNT = 20;
  localparam int GAP_CNT  = 10;
  localparam int TAIL     = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_level = 1'b0;
  logic short_press;
  logic long_press;
  logic double_click;
  logic held;

  btn_press_classifier #(
    .LONG_CNT (LONG_CNT),
    .GAP_CNT  (GAP_CNT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_level    (btn_level),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_click (double_click),
    .held         (held)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  held_lo[$];
  int  held_hi[$];
  bit  lvl_q[$];
  int  n_checks = 0;
  int  n_pass = 0;
  int  ep_end_req = 0;
  int  ep_end_done = 0;
  int  m_base = 0;
  int  m_cut = 0;

  function automatic string kname(input int k);
    case (k)
      0: return "short_press";
      1: return "long_press";
      2: return "double_click";
      default: return "none";
    endcase
  endfunction

  task automatic chk(input bit ok, input string name, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  // Monitor: pops the scoreboard whenever the DUT emits a pulse.
  always @(negedge clk) begin
    int   np;
    int   act;
    bit   exp_held;
    ev_t  e;
    if (rst) begin
      chk({short_press, long_press, double_click, held} == 4'b0, "reset_outputs",
          $sformatf("got %b%b%b%b expected 0000 at cycle %0d",
                    short_press, long_press, double_click, held, cyc));
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        chk(1'b0, "missed_pulse", $sformatf("got nothing expected %s at cycle %0d (now %0d)",
                                            kname(e.kind), e.cyc, cyc));
      end
      np = int'(short_press) + int'(long_press) + int'(double_click);
      if (np > 0) begin
        chk(np == 1, "one_hot_pulses", $sformatf("got %0d pulses expected 1 at cycle %0d", np, cyc));
        act = short_press ? 0 : (long_press ? 1 : 2);
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_pulse", $sformatf("got %s at cycle %0d expected none", kname(act), cyc));
        end else begin
          e = exp_q.pop_front();
          chk(e.kind == act && e.cyc == cyc, "pulse",
              $sformatf("got %s at cycle %0d expected %s at cycle %0d", kname(act), cyc, kname(e.kind), e.cyc));
        end
      end
      exp_held = 1'b0;
      foreach (held_lo[i]) if (cyc >= held_lo[i] && cyc <= held_hi[i]) exp_held = 1'b1;
      chk(held == exp_held, "held", $sformatf("got %b expected %b at cycle %0d", held, exp_held, cyc));
    end
    if (ep_end_req != ep_end_done) begin
      chk(exp_q.size() == 0, "leftover_expected",
          $sformatf("got %0d pulses still pending expected 0", exp_q.size()));
      exp_q.delete();
      ep_end_done = ep_end_req;
    end
  end

  task automatic add_ev(input int kind, input int c);
    ev_t e;
    if (c < m_cut) begin
      e.kind = kind;
      e.cyc  = m_base + c;
      exp_q.push_back(e);
    end
  endtask

  task automatic expect_long(input int r, input int f);
    int lo;
    int hi;
    lo = r + LONG_CNT + 1;
    hi = (f < m_cut - 1) ? f : m_cut - 1;
    add_ev(1, lo);
    if (lo <= hi) begin
      held_lo.push_back(m_base + lo);
      held_hi.push_back(m_base + hi);
    end
  endtask

  // Reference model: classify each press interval [r, f) of the level trace.
  task automatic model();
    int rs[$];
    int fs[$];
    int k;
    int n;
    int p;
    n = lvl_q.size();
    k = 0;
    while (k < n) begin
      if (lvl_q[k]) begin
        rs.push_back(k);
        while (k < n && lvl_q[k]) k++;
        fs.push_back(k);
      end else begin
        k++;
      end
    end
    p = 0;
    while (p < rs.size()) begin
      if (fs[p] - rs[p] > LONG_CNT) begin
        expect_long(rs[p], fs[p]);
        p++;
      end else begin
`ifdef BTN_DOUBLE_CLICK_EN
        if (p + 1 < rs.size() && rs[p+1] - fs[p] <= GAP_CNT) begin
          if (fs[p+1] - rs[p+1] > LONG_CNT) expect_long(rs[p+1], fs[p+1]);
          else add_ev(2, fs[p+1] + 1);
          p += 2;
        end else begin
          add_ev(0, fs[p] + GAP_CNT + 1);
          p++;
        end
`else
        add_ev(0, fs[p] + 1);
        p++;
`endif
      end
    end
  endtask

  task automatic append(input bit v, input int count);
    for (int i = 0; i < count; i++) lvl_q.push_back(v);
  endtask

  task automatic run_episode(input int reset_at);
    int n;
    n = lvl_q.size();
    rst = 1'b1;
    btn_level = lvl_q[0];
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_base = cyc;
    m_cut  = (reset_at < 0) ? n : reset_at;
    held_lo.delete();
    held_hi.delete();
    model();
    for (int k = 1; k < n; k++) begin
      @(posedge clk);
      #1;
      btn_level = lvl_q[k];
      if (k == reset_at) rst = 1'b1;
      else if (reset_at >= 0 && k == reset_at + 1) rst = 1'b0;
    end
    @(posedge clk);
    #1;
    ep_end_req++;
    @(posedge clk);
    #1;
    lvl_q.delete();
  endtask

  initial begin
    int np;
    // short press / macro-off immediate short
    append(0, 2); append(1, 5); append(0, TAIL); run_episode(-1);
    // double click with a 4-cycle gap
    append(0, 2); append(1, 5); append(0, 4); append(1, 5); append(0, TAIL); run_episode(-1);
    // long press held 30 cycles
    append(0, 2); append(1, 30); append(0, TAIL); run_episode(-1);
    // second rise exactly at the gap timeout, and one cycle too late
    append(0, 2); append(1, 5); append(0, GAP_CNT); append(1, 5); append(0, TAIL); run_episode(-1);
    append(0, 2); append(1, 5); append(0, GAP_CNT + 1); append(1, 5); append(0, TAIL); run_episode(-1);
    // reset three cycles after release discards the pending press
    append(0, 2); append(1, 5); append(0, 3 + 25); run_episode(2 + 5 + 3);
    // button already down at reset release
    append(1, 5); append(0, TAIL); run_episode(-1);
    // long threshold boundary: 20 cycles is short, 21 is long
    append(0, 2); append(1, LONG_CNT); append(0, TAIL); run_episode(-1);
    append(0, 2); append(1, LONG_CNT + 1); append(0, TAIL); run_episode(-1);
    // long second press of a double click
    append(0, 2); append(1, 3); append(0, 2); append(1, 25); append(0, TAIL); run_episode(-1);
    for (int ep = 0; ep < 20; ep++) begin
      np = $urandom_range(1, 5);
      append(0, $urandom_range(0, 3));
      for (int p = 0; p < np; p++) begin
        if ($urandom_range(0, 3) == 0) append(1, $urandom_range(LONG_CNT - 2, LONG_CNT + 6));
        else append(1, $urandom_range(1, 8));
        append(0, $urandom_range(1, GAP_CNT + 4));
      end
      append(0, TAIL);
      run_episode(-1);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
